// File: rtl/rs_encoder_line_rr_dispatch.sv
// Deals whole RS blocks round-robin across NUM_RS_UNITS encoder units and
// gathers the encoded lines back in block order through a registered output stage.
module rs_encoder_line_rr_dispatch #(
    parameter int DATA_W       = 512,
    parameter int PARITY_W     = 256,
    parameter int NUM_LINES    = 8,
    parameter int NUM_RS_UNITS = 4,
    parameter int UNIT_W       = (NUM_RS_UNITS > 1) ? $clog2(NUM_RS_UNITS) : 1,
    parameter int LINE_W       = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             src_disp_line_val,
    input  logic [DATA_W-1:0]                src_disp_line,
    output logic                             disp_src_line_rdy,
    output logic [NUM_RS_UNITS-1:0]          disp_unit_line_vals,
    output logic [DATA_W-1:0]                disp_unit_line,
    input  logic [NUM_RS_UNITS-1:0]          unit_disp_line_rdys,
    input  logic [NUM_RS_UNITS-1:0]          unit_coll_line_vals,
    input  logic [NUM_RS_UNITS*DATA_W-1:0]   unit_coll_line_datas,
    input  logic [NUM_RS_UNITS*PARITY_W-1:0] unit_coll_line_parities,
    output logic [NUM_RS_UNITS-1:0]          coll_unit_line_rdys,
    output logic                             disp_dst_line_val,
    output logic [DATA_W-1:0]                disp_dst_line,
    output logic [PARITY_W-1:0]              disp_dst_parity,
    output logic                             disp_dst_last,
    input  logic                             dst_disp_line_rdy,
    output logic [UNIT_W:0]                  blocks_in_flight
);

    localparam logic [UNIT_W-1:0] LAST_UNIT = UNIT_W'(NUM_RS_UNITS - 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(NUM_LINES - 1);
    localparam logic [UNIT_W:0]   FULL_CNT  = (UNIT_W + 1)'(NUM_RS_UNITS);

    logic [UNIT_W-1:0]   r_wr_unit;
    logic [LINE_W-1:0]   r_wr_line;
    logic [UNIT_W-1:0]   r_rd_unit;
    logic [LINE_W-1:0]   r_rd_line;
    logic [UNIT_W:0]     r_bif;
    logic                r_out_val;
    logic                r_out_last;
    logic [DATA_W-1:0]   r_out_data;
    logic [PARITY_W-1:0] r_out_parity;

    logic                w_stall;
    logic                w_in_rdy;
    logic                w_src_rdy;
    logic                w_src_hs;
    logic                w_load;
    logic                w_sel_val;
    logic [DATA_W-1:0]   w_sel_data;
    logic [PARITY_W-1:0] w_sel_par;
    logic                w_unit_hs;
    logic                w_out_hs;
    logic                w_bif_inc;
    logic                w_bif_dec;

    // Only block starts are held off: a block already begun always completes.
    assign w_stall   = (r_wr_line == '0) && (r_bif == FULL_CNT);
    assign w_src_rdy = w_in_rdy & ~w_stall & ~rst;
    assign w_src_hs  = src_disp_line_val & w_src_rdy;
    assign w_load    = (~r_out_val | dst_disp_line_rdy) & ~rst;
    assign w_unit_hs = w_load & w_sel_val;
    assign w_out_hs  = r_out_val & dst_disp_line_rdy;
    assign w_bif_inc = w_src_hs & (r_wr_line == '0);
    assign w_bif_dec = w_out_hs & r_out_last;

    always_comb begin
        w_in_rdy   = 1'b0;
        w_sel_val  = 1'b0;
        w_sel_data = '0;
        w_sel_par  = '0;
        disp_unit_line_vals = '0;
        coll_unit_line_rdys = '0;
        for (int u = 0; u < NUM_RS_UNITS; u++) begin
            if (r_wr_unit == UNIT_W'(u)) begin
                w_in_rdy = unit_disp_line_rdys[u];
                disp_unit_line_vals[u] = src_disp_line_val & ~w_stall & ~rst;
            end
            if (r_rd_unit == UNIT_W'(u)) begin
                w_sel_val  = unit_coll_line_vals[u];
                w_sel_data = unit_coll_line_datas[u*DATA_W +: DATA_W];
                w_sel_par  = unit_coll_line_parities[u*PARITY_W +: PARITY_W];
                coll_unit_line_rdys[u] = w_load;
            end
        end
    end

    assign disp_src_line_rdy = w_src_rdy;
    assign disp_unit_line    = rst ? '0 : src_disp_line;
    assign disp_dst_line_val = r_out_val;
    assign disp_dst_line     = r_out_data;
    assign disp_dst_parity   = r_out_parity;
    assign disp_dst_last     = r_out_last;
    assign blocks_in_flight  = r_bif;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_unit <= '0;
            r_wr_line <= '0;
        end else if (w_src_hs) begin
            if (r_wr_line == LAST_LINE) begin
                r_wr_line <= '0;
                r_wr_unit <= (r_wr_unit == LAST_UNIT) ? '0 : r_wr_unit + UNIT_W'(1);
            end else begin
                r_wr_line <= r_wr_line + LINE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_unit <= '0;
            r_rd_line <= '0;
        end else if (w_unit_hs) begin
            if (r_rd_line == LAST_LINE) begin
                r_rd_line <= '0;
                r_rd_unit <= (r_rd_unit == LAST_UNIT) ? '0 : r_rd_unit + UNIT_W'(1);
            end else begin
                r_rd_line <= r_rd_line + LINE_W'(1);
            end
        end
    end

    // Data and parity are only written on a unit handshake, so they hold through sink stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_val    <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
            r_out_parity <= '0;
        end else if (w_unit_hs) begin
            r_out_val    <= 1'b1;
            r_out_last   <= (r_rd_line == LAST_LINE);
            r_out_data   <= w_sel_data;
            r_out_parity <= w_sel_par;
        end else if (w_load) begin
            r_out_val  <= 1'b0;
            r_out_last <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bif <= '0;
        end else if (w_bif_inc && !w_bif_dec) begin
            r_bif <= r_bif + (UNIT_W + 1)'(1);
        end else if (w_bif_dec && !w_bif_inc) begin
            r_bif <= r_bif - (UNIT_W + 1)'(1);
        end
    end

endmodule

// File: tb/tb_rs_encoder_line_rr_dispatch.sv
// Bench for rs_encoder_line_rr_dispatch with 3 units of 4-line blocks: a table of
// random-traffic scenarios plus backpressure and mid-block reset sequences.
module tb_rs_encoder_line_rr_dispatch;

    localparam int DW = 32;
    localparam int PW = 16;
    localparam int NL = 4;
    localparam int NU = 3;
    localparam int UW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              src_disp_line_val = 1'b0;
    logic [DW-1:0]     src_disp_line = '0;
    logic              disp_src_line_rdy;
    logic [NU-1:0]     disp_unit_line_vals;
    logic [DW-1:0]     disp_unit_line;
    logic [NU-1:0]     unit_disp_line_rdys = '0;
    logic [NU-1:0]     unit_coll_line_vals = '0;
    logic [NU*DW-1:0]  unit_coll_line_datas = '0;
    logic [NU*PW-1:0]  unit_coll_line_parities = '0;
    logic [NU-1:0]     coll_unit_line_rdys;
    logic              disp_dst_line_val;
    logic [DW-1:0]     disp_dst_line;
    logic [PW-1:0]     disp_dst_parity;
    logic              disp_dst_last;
    logic              dst_disp_line_rdy = 1'b0;
    logic [UW:0]       blocks_in_flight;

    always #5 clk = ~clk;

    rs_encoder_line_rr_dispatch #(
        .DATA_W(DW), .PARITY_W(PW), .NUM_LINES(NL), .NUM_RS_UNITS(NU)
    ) dut (
        .clk(clk), .rst(rst),
        .src_disp_line_val(src_disp_line_val), .src_disp_line(src_disp_line),
        .disp_src_line_rdy(disp_src_line_rdy),
        .disp_unit_line_vals(disp_unit_line_vals), .disp_unit_line(disp_unit_line),
        .unit_disp_line_rdys(unit_disp_line_rdys),
        .unit_coll_line_vals(unit_coll_line_vals),
        .unit_coll_line_datas(unit_coll_line_datas),
        .unit_coll_line_parities(unit_coll_line_parities),
        .coll_unit_line_rdys(coll_unit_line_rdys),
        .disp_dst_line_val(disp_dst_line_val), .disp_dst_line(disp_dst_line),
        .disp_dst_parity(disp_dst_parity), .disp_dst_last(disp_dst_last),
        .dst_disp_line_rdy(dst_disp_line_rdy),
        .blocks_in_flight(blocks_in_flight)
    );

    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } ue_t;

    typedef struct {
        int nblk;
        int sink_pct;
        int src_gap;
        int u0_lat;
        bit urand;
        bit nobub;
        int exp_lines;
        int exp_next;
    } row_t;

    ue_t           uq [NU][$];
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    int  acc, popped, emitted, cyc;
    int  checks, errors;
    int  sink_pct, src_gap, u0_lat;
    bit  unit_rand, src_fired;
    int  first_out, last_out;
    bit            hold_v;
    logic [DW-1:0] hold_d;
    logic [PW-1:0] hold_p;
    logic          hold_l;

    function automatic logic [PW-1:0] par_of(logic [DW-1:0] d);
        return d[15:0] ^ d[31:16] ^ 16'hA5A5;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        src_q.delete();
        exp_q.delete();
        for (int u = 0; u < NU; u++) uq[u].delete();
        acc = 0; popped = 0; emitted = 0;
        src_fired = 1'b0; hold_v = 1'b0;
        first_out = 0; last_out = 0;
    endtask

    // Spec-level model: block k goes to unit k mod NU, emission order equals acceptance order.
    always @(negedge clk) begin : mon
        int wu, ru, started, done;
        bit stall_m, ld, lst;
        logic [DW-1:0] e;
        ue_t ue;
        if (!rst) begin
            started = (acc + NL - 1) / NL;
            done    = emitted / NL;
            wu      = (acc / NL) % NU;
            ru      = (popped / NL) % NU;
            stall_m = ((acc % NL) == 0) && ((started - done) == NU);
            check("blocks_in_flight", 64'(blocks_in_flight), 64'(started - done));
            check("src_rdy", 64'(disp_src_line_rdy), 64'(unit_disp_line_rdys[wu] && !stall_m));
            check("unit_vals", 64'(disp_unit_line_vals),
                  (src_disp_line_val && !stall_m) ? 64'(1 << wu) : 64'd0);
            ld = !disp_dst_line_val || dst_disp_line_rdy;
            check("coll_rdys", 64'(coll_unit_line_rdys), ld ? 64'(1 << ru) : 64'd0);
            if (hold_v) begin
                check("stall_val", 64'(disp_dst_line_val), 64'd1);
                check("stall_data", 64'(disp_dst_line), 64'(hold_d));
                check("stall_parity", 64'(disp_dst_parity), 64'(hold_p));
                check("stall_last", 64'(disp_dst_last), 64'(hold_l));
            end
            hold_v = disp_dst_line_val && !dst_disp_line_rdy;
            hold_d = disp_dst_line;
            hold_p = disp_dst_parity;
            hold_l = disp_dst_last;

            if (src_disp_line_val && disp_src_line_rdy) begin
                ue.d = src_disp_line;
                ue.t = cyc + 1 + ((wu == 0) ? u0_lat : 0);
                uq[wu].push_back(ue);
                exp_q.push_back(src_disp_line);
                if (src_q.size() > 0) void'(src_q.pop_front());
                acc++;
                src_fired = 1'b1;
            end
            for (int u = 0; u < NU; u++) begin
                if (unit_coll_line_vals[u] && coll_unit_line_rdys[u]) begin
                    if (uq[u].size() > 0) void'(uq[u].pop_front());
                    popped++;
                end
            end
            if (disp_dst_line_val && dst_disp_line_rdy) begin
                if (exp_q.size() == 0) begin
                    check("extra_output", 64'd1, 64'd0);
                end else begin
                    e   = exp_q.pop_front();
                    lst = (emitted % NL) == (NL - 1);
                    check("out_data", 64'(disp_dst_line), 64'(e));
                    check("out_last", 64'(disp_dst_last), 64'(lst));
                    if (lst) check("out_parity", 64'(disp_dst_parity), 64'(par_of(e)));
                end
                if (emitted == 0) first_out = cyc;
                last_out = cyc;
                emitted++;
            end
        end
    end

    // Source, unit and sink behaviour, updated just after each active edge.
    initial begin : drv
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                src_disp_line_val       = 1'b0;
                unit_coll_line_vals     = '0;
                unit_coll_line_datas    = '0;
                unit_coll_line_parities = '0;
                src_fired               = 1'b0;
            end else begin
                if (!(src_disp_line_val && !src_fired)) begin
                    if (src_q.size() > 0 && $urandom_range(0, 99) >= src_gap) begin
                        src_disp_line_val = 1'b1;
                        src_disp_line     = src_q[0];
                    end else begin
                        src_disp_line_val = 1'b0;
                    end
                end
                src_fired = 1'b0;
                for (int u = 0; u < NU; u++) begin
                    if (uq[u].size() > 0 && uq[u][0].t <= cyc) begin
                        unit_coll_line_vals[u]               = 1'b1;
                        unit_coll_line_datas[u*DW +: DW]     = uq[u][0].d;
                        unit_coll_line_parities[u*PW +: PW]  = par_of(uq[u][0].d);
                    end else begin
                        unit_coll_line_vals[u]               = 1'b0;
                        unit_coll_line_datas[u*DW +: DW]     = '0;
                        unit_coll_line_parities[u*PW +: PW]  = '0;
                    end
                end
            end
            for (int u = 0; u < NU; u++)
                unit_disp_line_rdys[u] = unit_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            dst_disp_line_rdy = ($urandom_range(0, 99) < sink_pct);
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic push_lines(int n);
        for (int i = 0; i < n; i++) src_q.push_back(DW'($urandom));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", 64'(n < 3000), 64'd1);
        repeat (3) @(posedge clk);
    endtask

    // Momentarily offers a line mid-cycle to see which unit the next block would use.
    task automatic probe(int expu);
        @(posedge clk);
        #2;
        src_disp_line_val = 1'b1;
        src_disp_line     = 32'hDEAD_BEEF;
        #1;
        check("next_unit", 64'(disp_unit_line_vals), 64'(1 << expu));
        src_disp_line_val = 1'b0;
    endtask

    row_t rows[5];

    initial begin : main
        int n;
        rows[0] = '{nblk: 5, sink_pct: 100, src_gap: 0,  u0_lat: 0,  urand: 0, nobub: 1, exp_lines: 20, exp_next: 2};
        rows[1] = '{nblk: 3, sink_pct: 100, src_gap: 0,  u0_lat: 20, urand: 0, nobub: 0, exp_lines: 12, exp_next: 0};
        rows[2] = '{nblk: 7, sink_pct: 50,  src_gap: 30, u0_lat: 0,  urand: 1, nobub: 0, exp_lines: 28, exp_next: 1};
        rows[3] = '{nblk: 1, sink_pct: 100, src_gap: 0,  u0_lat: 0,  urand: 0, nobub: 1, exp_lines: 4,  exp_next: 1};
        rows[4] = '{nblk: 6, sink_pct: 70,  src_gap: 10, u0_lat: 5,  urand: 1, nobub: 0, exp_lines: 24, exp_next: 0};
        checks = 0; errors = 0; cyc = 0;
        sink_pct = 100; src_gap = 0; u0_lat = 0; unit_rand = 1'b0;
        clear_model();

        #1;
        check("rst_out_val", 64'(disp_dst_line_val), 64'd0);
        check("rst_out_last", 64'(disp_dst_last), 64'd0);
        check("rst_out_data", 64'(disp_dst_line), 64'd0);
        check("rst_bif", 64'(blocks_in_flight), 64'd0);
        check("rst_src_rdy", 64'(disp_src_line_rdy), 64'd0);
        check("rst_coll_rdys", 64'(coll_unit_line_rdys), 64'd0);

        for (int r = 0; r < 5; r++) begin
            do_reset();
            sink_pct  = rows[r].sink_pct;
            src_gap   = rows[r].src_gap;
            u0_lat    = rows[r].u0_lat;
            unit_rand = rows[r].urand;
            push_lines(rows[r].nblk * NL);
            drain();
            check("row_lines", 64'(emitted), 64'(rows[r].exp_lines));
            check("row_bif_end", 64'(blocks_in_flight), 64'd0);
            if (rows[r].nobub) check("row_no_bubble", 64'(last_out - first_out + 1), 64'(rows[r].exp_lines));
            unit_rand = 1'b0;
            probe(rows[r].exp_next);
        end

        // Sink blocked: three blocks fill all units, the fourth waits at its boundary.
        do_reset();
        sink_pct = 0; src_gap = 0; u0_lat = 0;
        push_lines(4 * NL);
        repeat (40) @(posedge clk);
        #2;
        check("bp_bif_full", 64'(blocks_in_flight), 64'd3);
        check("bp_src_rdy", 64'(disp_src_line_rdy), 64'd0);
        check("bp_accepted", 64'(acc), 64'(3 * NL));
        sink_pct = 100;
        drain();
        check("bp_lines", 64'(emitted), 64'(4 * NL));
        probe(1);

        // Asynchronous reset while the fourth line of block 2 is being offered.
        do_reset();
        sink_pct = 100;
        push_lines(3 * NL);
        n = 0;
        while (acc < 2 * NL + 3 && n < 200) begin
            @(posedge clk);
            #3;
            n++;
        end
        check("mr_reach_line3", 64'(acc), 64'(2 * NL + 3));
        rst = 1'b1;
        #1;
        check("mr_out_val", 64'(disp_dst_line_val), 64'd0);
        check("mr_out_last", 64'(disp_dst_last), 64'd0);
        check("mr_out_data", 64'(disp_dst_line), 64'd0);
        check("mr_out_parity", 64'(disp_dst_parity), 64'd0);
        check("mr_unit_vals", 64'(disp_unit_line_vals), 64'd0);
        check("mr_src_rdy", 64'(disp_src_line_rdy), 64'd0);
        check("mr_coll_rdys", 64'(coll_unit_line_rdys), 64'd0);
        check("mr_bif", 64'(blocks_in_flight), 64'd0);
        clear_model();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        push_lines(NL);
        drain();
        check("mr_lines", 64'(emitted), 64'(NL));
        probe(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_encoder_line_rr_dispatch.md
Name: rs_encoder_line_rr_dispatch

Overview:
- Parametrised successor to the fixed 32-unit RS line encoder mux.
- Takes one line stream of RS blocks (NUM_LINES lines per block) and deals whole blocks round-robin across NUM_RS_UNITS external encoder units.
- Collects encoded lines back in strict block order and emits them through a registered output stage with a per-block last flag.
- Accepts any block count; a multiple of NUM_RS_UNITS is not required. It sits between the line source and the line/parity sink.

Parameters:
- DATA_W, 512, line width in bits.
- PARITY_W, 256, parity width in bits.
- NUM_LINES, 8, lines per RS block (>=1).
- NUM_RS_UNITS, 4, number of encoder units (>=1, any value, not only powers of 2).
- UNIT_W, $clog2(NUM_RS_UNITS) min 1, unit pointer width.
- LINE_W, $clog2(NUM_LINES) min 1, line counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- src_disp_line_val  in  1  input line valid.
- src_disp_line  in  DATA_W  input line.
- disp_src_line_rdy  out  1  input ready.
- disp_unit_line_vals  out  NUM_RS_UNITS  per-unit input valid (one-hot or zero).
- disp_unit_line  out  DATA_W  shared line to units (equal to src_disp_line).
- unit_disp_line_rdys  in  NUM_RS_UNITS  per-unit input ready.
- unit_coll_line_vals  in  NUM_RS_UNITS  per-unit output valid.
- unit_coll_line_datas  in  NUM_RS_UNITS*DATA_W  per-unit output lines.
- unit_coll_line_parities  in  NUM_RS_UNITS*PARITY_W  per-unit parity.
- coll_unit_line_rdys  out  NUM_RS_UNITS  per-unit output ready (one-hot or zero).
- disp_dst_line_val  out  1  output valid.
- disp_dst_line  out  DATA_W  output line.
- disp_dst_parity  out  PARITY_W  parity, meaningful when disp_dst_last=1.
- disp_dst_last  out  1  last line of block.
- dst_disp_line_rdy  in  1  output ready.
- blocks_in_flight  out  UNIT_W+1  blocks dispatched but not fully emitted.

Behaviour:
- Reset (async, rst=1) clears:
  - pointers: wr_unit=0, wr_line=0, rd_unit=0, rd_line=0;
  - counters: blocks_in_flight=0;
  - outputs: disp_dst_line_val=0, disp_dst_last=0, data/parity regs=0.
- All outputs are low while in reset. Reset mid-block discards partial state; the bench must also reset the units.
- Dispatch side:
  - disp_unit_line_vals[wr_unit] = src_disp_line_val & ~stall; all other bits 0.
  - disp_src_line_rdy = unit_disp_line_rdys[wr_unit] & ~stall.
  - stall = (wr_line==0) & (blocks_in_flight==NUM_RS_UNITS). A new block is held off when every unit already holds an unemitted block.
  - On src handshake: wr_line increments. At wr_line==NUM_LINES-1 it wraps to 0 and wr_unit advances, wrapping from NUM_RS_UNITS-1 to 0.
  - No bubble between blocks.
- Collect side:
  - Output register loads when ~disp_dst_line_val | dst_disp_line_rdy.
  - coll_unit_line_rdys[rd_unit] = that load condition; all other bits 0.
  - On unit handshake the register captures the data and parity of rd_unit, and disp_dst_last = (rd_line==NUM_LINES-1). rd_line and rd_unit advance with the same wrap rules as the dispatch side.
  - disp_dst_line_val clears on an output handshake with no new load.
  - Unit-to-output latency is 1 cycle. Full throughput is 1 line/cycle under continuous ready.
  - Output data and parity are stable while val=1 and rdy=0.
- blocks_in_flight:
  - +1 on a src handshake with wr_line==0.
  - -1 on an output handshake with disp_dst_last=1.
  - Both in the same cycle: unchanged.
  - Never exceeds NUM_RS_UNITS and never underflows.
- Ordering: blocks emerge in input order regardless of which unit finishes first. A unit that is valid but not selected is held by rdy=0.
- Partial final group (block count not a multiple of NUM_RS_UNITS): the pointers simply stop mid-rotation. No padding or flush is needed. The next block continues from the current wr_unit.
- NUM_RS_UNITS=1 and NUM_LINES=1 are legal: the pointer or counter stays at 0 and every line is last.

Test Plan:
- NUM_RS_UNITS=4, NUM_LINES=8, 4 blocks, ideal unit models, rdy=1 throughout -> 32 output lines in input order, last on lines 7/15/23/31, blocks_in_flight returns to 0.
- NUM_RS_UNITS=3, 5 blocks (not a multiple of 3) -> units used in order 0,1,2,0,1; all 5 blocks emitted in order; next block dispatches to unit 2.
- Unit 1 finishes before unit 0 (unit 0 has 20-cycle extra latency) -> coll_unit_line_rdys[1]=0 until block 0 fully emitted; order is preserved.
- dst_disp_line_rdy toggled randomly -> no loss or duplication; data is held stable during stall; at 1 line/cycle with rdy=1 there is no bubble.
- Sink held rdy=0 with 4 units -> after 4 blocks accepted, disp_src_line_rdy=0 at a block boundary; blocks_in_flight=4; it resumes after the first last-line handshake.
- Assert rst mid-block (line 3 of block 2) -> all outputs 0 within the same cycle, pointers 0; the post-reset block goes to unit 0 and emits correctly.
